// File: rtl/reg_write_pkg.sv
// -----------------------------------------------------------------------------
// reg_write_pkg
// Shared types and constants for the register write sequencer.
//   NREG        : number of downstream 4-bit registers (fixed at 4)
//   dest_t      : destination register index (2 bits)
//   nibble_t    : register data value (4 bits)
//   LOAD_IDLE   : value of the active-low load strobe bus when no load occurs
//   state_t     : sequencer FSM states {IDLE, ISSUE}
//   wr_entry_t  : one queued write {dest, data}, 6 bits
//   load_strobe : converts a destination index into an active-low one-cold strobe
// -----------------------------------------------------------------------------
package reg_write_pkg;

    localparam int NREG = 4;

    typedef logic [1:0] dest_t;
    typedef logic [3:0] nibble_t;

    localparam logic [NREG-1:0] LOAD_IDLE = 4'b1111;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    typedef struct packed {
        dest_t   dest;
        nibble_t data;
    } wr_entry_t;

    localparam int ENTRY_W = $bits(wr_entry_t);

    // Exactly one bit low: the bit selected by dest.
    function automatic logic [NREG-1:0] load_strobe(input dest_t dest);
        return ~(NREG'(1) << dest);
    endfunction

endpackage

// File: rtl/reg_write_seq_nibble_fifo.sv
// -----------------------------------------------------------------------------
// nibble_fifo
// Small first-word-fall-through FIFO holding queued register writes.
// The head entry is visible combinationally so the sequencer can inspect
// and pop it on the same edge; storage is therefore kept in fabric
// registers rather than a block RAM with a registered read port.
//
// Parameters
//   DEPTH  : number of entries (1..4)
//   WIDTH  : entry width in bits
//   CNT_W  : width of the occupancy count
// Ports
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset, empties the FIFO
//   i_push       : write i_push_data (ignored when full)
//   i_push_data  : entry to append
//   i_pop        : discard the head entry (ignored when empty)
//   o_head       : current head entry (meaningful when o_count != 0)
//   o_count      : number of stored entries
// -----------------------------------------------------------------------------
module nibble_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 6,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    // Pointers wrap explicitly because DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_push = i_push && (r_count != CNT_W'(DEPTH));
    assign w_do_pop  = i_pop  && (r_count != '0);

    // Storage contents are don't-care while empty, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/reg_write_seq.sv
// -----------------------------------------------------------------------------
// reg_write_seq
// Queues register write requests and replays them onto a shared 4-bit data
// bus with one active-low load strobe per destination register, one write
// per cycle. Issue can be stalled with hold while the queue keeps accepting.
//
// Optional feature: define REG_WRITE_SEQ_SUPPRESS_EN to keep a shadow copy of
// every register; a queued write whose data already matches the shadow of
// its destination is dropped at issue time and produces no strobe.
//
// Parameters
//   DEPTH : write-queue entries (1..4)
//   NREG  : number of downstream registers (4)
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous active-high reset
//   req_valid : write request present
//   req_ready : queue can accept (transfer when valid & ready at an edge)
//   req_dest  : destination register index
//   req_data  : value to write
//   hold      : stall issue; queue still accepts while not full
//   load_n    : registered per-register load strobes, active low, one-cold
//   wr_data   : registered shared data bus, holds its last value when idle
//   busy      : queue non-empty or a strobe currently driven
// -----------------------------------------------------------------------------
module reg_write_seq
    import reg_write_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int NREG  = reg_write_pkg::NREG
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_dest,
    input  logic [3:0]      req_data,
    input  logic            hold,
    output logic [NREG-1:0] load_n,
    output logic [3:0]      wr_data,
    output logic            busy
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    wr_entry_t       w_push_entry;
    wr_entry_t       w_head;
    logic [CNT_W-1:0] w_count;
    logic            w_push;
    logic            w_pop;
    logic            w_can_issue;
    logic            w_suppress;
    logic            w_strobe;

    state_t          r_state;
    state_t          w_state_next;
    logic [NREG-1:0] r_load_n;
    logic [NREG-1:0] w_load_n_next;
    nibble_t         r_wr_data;
    nibble_t         w_wr_data_next;

    // ------------------------------------------------------------------
    // Request queue. Ready is based on the current count only: a pop on
    // the same edge does not free a slot for the incoming request.
    // ------------------------------------------------------------------
    assign req_ready         = (w_count < CNT_W'(DEPTH));
    assign w_push            = req_valid && req_ready;
    assign w_push_entry.dest = req_dest;
    assign w_push_entry.data = req_data;

    nibble_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    // ------------------------------------------------------------------
    // Redundant-write suppression
    // ------------------------------------------------------------------
`ifdef REG_WRITE_SEQ_SUPPRESS_EN
    logic [NREG*4-1:0] w_shadow_flat;
    nibble_t           w_shadow_head;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_shadow
            nibble_t r_shadow;

            // Tracks the value last strobed into register gi.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_shadow <= '0;
                end else if (w_strobe && (w_head.dest == dest_t'(gi))) begin
                    r_shadow <= w_head.data;
                end
            end

            assign w_shadow_flat[gi*4 +: 4] = r_shadow;
        end
    endgenerate

    assign w_shadow_head = w_shadow_flat[{w_head.dest, 2'b00} +: 4];
    // Compared against the head at issue, so earlier queued writes to the
    // same register have already updated the shadow.
    assign w_suppress    = (w_head.data == w_shadow_head);
`else
    assign w_suppress = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer FSM. ISSUE means the head is popped on the coming edge;
    // the decision depends only on queue occupancy and hold, so a request
    // accepted into an empty queue is popped on the very next edge.
    // ------------------------------------------------------------------
    assign w_can_issue = (w_count != '0) && !hold;

    always_comb begin
        w_state_next   = IDLE;
        w_pop          = 1'b0;
        w_strobe       = 1'b0;
        w_load_n_next  = LOAD_IDLE;
        w_wr_data_next = r_wr_data;

        case (r_state)
            IDLE: begin
                if (w_can_issue) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (w_can_issue) begin
                    w_state_next = ISSUE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        if (w_state_next == ISSUE) begin
            w_pop    = 1'b1;
            // A suppressed entry still consumes its issue slot.
            w_strobe = !w_suppress;
        end

        if (w_strobe) begin
            w_load_n_next  = load_strobe(w_head.dest);
            w_wr_data_next = w_head.data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_load_n  <= LOAD_IDLE;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_next;
            r_load_n  <= w_load_n_next;
            r_wr_data <= w_wr_data_next;
        end
    end

    assign load_n  = r_load_n;
    assign wr_data = r_wr_data;
    assign busy    = (w_count != '0) || (r_load_n != LOAD_IDLE);

endmodule

// File: tb/tb_reg_write_seq.sv
module tb_reg_write_seq;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_dest;
    logic [3:0] req_data;
    logic       hold;
    logic [3:0] load_n;
    logic [3:0] wr_data;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Expected strobes {load_n, wr_data}, oldest first.
    logic [7:0] sb[$];
    logic [3:0] model_shadow [4];

    reg_write_seq #(.DEPTH(2), .NREG(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dest  (req_dest),
        .req_data  (req_data),
        .hold      (hold),
        .load_n    (load_n),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Record the strobe an accepted request should eventually produce.
    task automatic push_exp(input logic [1:0] d, input logic [3:0] v);
`ifdef REG_WRITE_SEQ_SUPPRESS_EN
        if (v == model_shadow[d]) return;
        model_shadow[d] = v;
`endif
        sb.push_back({~(4'b0001 << d), v});
    endtask

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < 4; i++) model_shadow[i] = 4'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        req_valid = 1'b0;
        hold      = 1'b0;
        clear_model();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Scoreboard side: every strobe seen must be the next expected one.
    always @(negedge clk) begin
        if (!reset && load_n != 4'b1111) begin
            $display("strobe load_n=%b wr_data=%h", load_n, wr_data);
            check("one_cold", $countones(~load_n), 1);
            if (sb.size() == 0) begin
                check("unexpected_strobe", {load_n, wr_data}, {4'b1111, 4'h0});
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                check("sb_strobe", {load_n, wr_data}, e);
            end
        end
    end

    typedef struct {
        logic [1:0] dest;
        logic [3:0] data;
        logic [3:0] exp_load_n;
        logic [3:0] exp_wr_data;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{2'd2, 4'hA, 4'b1011, 4'hA};
        vecs[1] = '{2'd0, 4'h1, 4'b1110, 4'h1};
        vecs[2] = '{2'd1, 4'hF, 4'b1101, 4'hF};
        vecs[3] = '{2'd3, 4'h6, 4'b0111, 4'h6};
        vecs[4] = '{2'd2, 4'h5, 4'b1011, 4'h5};
        vecs[5] = '{2'd0, 4'hE, 4'b1110, 4'hE};
        vecs[6] = '{2'd3, 4'h9, 4'b0111, 4'h9};
        vecs[7] = '{2'd1, 4'h2, 4'b1101, 4'h2};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_dest  = 2'd0;
        req_data  = 4'h0;
        hold      = 1'b0;
        clear_model();
        #1;
        check("rst_load_n", load_n, 4'b1111);
        check("rst_wr_data", wr_data, 4'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", req_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        // Single writes into an empty queue: strobe in cycle N+1 only.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            req_valid = 1'b1;
            req_dest  = vecs[i].dest;
            req_data  = vecs[i].data;
            check("tbl_ready", req_ready, 1'b1);
            push_exp(vecs[i].dest, vecs[i].data);
            @(negedge clk);
            req_valid = 1'b0;
            check("tbl_n_load_n", load_n, 4'b1111);
            check("tbl_n_busy", busy, 1'b1);
            @(negedge clk);
            check("tbl_n1_load_n", load_n, vecs[i].exp_load_n);
            check("tbl_n1_wr_data", wr_data, vecs[i].exp_wr_data);
            @(negedge clk);
            check("tbl_n2_load_n", load_n, 4'b1111);
            check("tbl_n2_busy", busy, 1'b0);
            check("tbl_n2_wr_hold", wr_data, vecs[i].exp_wr_data);
        end

        // Reset in the middle of a strobe with another entry still queued.
        @(negedge clk);
        req_valid = 1'b1; req_dest = 2'd2; req_data = 4'hB;
        push_exp(2'd2, 4'hB);
        @(negedge clk);
        req_dest = 2'd0; req_data = 4'h4;
        check("rst_seq_ready", req_ready, 1'b1);
        push_exp(2'd0, 4'h4);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_seq_pre_load_n", load_n, 4'b1011);
        check("rst_seq_pre_wr", wr_data, 4'hB);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_load_n", load_n, 4'b1111);
        check("async_rst_wr_data", wr_data, 4'h0);
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_ready", req_ready, 1'b1);
        clear_model();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", load_n, 4'b1111);
            check("post_rst_busy", busy, 1'b0);
        end

        // Hold with full queue, then release: back-to-back strobes.
        @(negedge clk);
        hold = 1'b1;
        req_valid = 1'b1; req_dest = 2'd0; req_data = 4'h3;
        check("hold_ready0", req_ready, 1'b1);
        push_exp(2'd0, 4'h3);
        @(negedge clk);
        req_dest = 2'd1; req_data = 4'h7;
        check("hold_ready1", req_ready, 1'b1);
        push_exp(2'd1, 4'h7);
        @(negedge clk);
        req_dest = 2'd3; req_data = 4'hC;
        check("full_ready", req_ready, 1'b0);
        check("full_busy", busy, 1'b1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("full_wait_ready", req_ready, 1'b0);
            check("hold_no_strobe", load_n, 4'b1111);
        end
        hold = 1'b0;
        @(negedge clk);
        check("rel_s1_load_n", load_n, 4'b1110);
        check("rel_s1_wr", wr_data, 4'h3);
        check("rel_s1_ready", req_ready, 1'b1);
        push_exp(2'd3, 4'hC);
        @(negedge clk);
        req_valid = 1'b0;
        check("rel_s2_load_n", load_n, 4'b1101);
        check("rel_s2_wr", wr_data, 4'h7);
        check("pushpop_ready", req_ready, 1'b1);
        check("pushpop_busy", busy, 1'b1);
        @(negedge clk);
        check("rel_s3_load_n", load_n, 4'b0111);
        check("rel_s3_wr", wr_data, 4'hC);
        @(negedge clk);
        check("rel_done_load_n", load_n, 4'b1111);
        check("rel_done_busy", busy, 1'b0);

        // Duplicate write sequence: (1,5), (1,5), (1,0) back to back.
        do_reset();
        @(negedge clk);
        req_valid = 1'b1; req_dest = 2'd1; req_data = 4'h5;
        push_exp(2'd1, 4'h5);
        @(negedge clk);
        push_exp(2'd1, 4'h5);
        @(negedge clk);
        req_data = 4'h0;
        check("dup_s1_load_n", load_n, 4'b1101);
        check("dup_s1_wr", wr_data, 4'h5);
        push_exp(2'd1, 4'h0);
        @(negedge clk);
        req_valid = 1'b0;
`ifdef REG_WRITE_SEQ_SUPPRESS_EN
        check("dup_s2_load_n", load_n, 4'b1111);
`else
        check("dup_s2_load_n", load_n, 4'b1101);
`endif
        check("dup_s2_wr", wr_data, 4'h5);
        @(negedge clk);
        check("dup_s3_load_n", load_n, 4'b1101);
        check("dup_s3_wr", wr_data, 4'h0);
        @(negedge clk);
        check("dup_done_busy", busy, 1'b0);

        // Write of zero straight after reset.
        do_reset();
        @(negedge clk);
        req_valid = 1'b1; req_dest = 2'd2; req_data = 4'h0;
        push_exp(2'd2, 4'h0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
`ifdef REG_WRITE_SEQ_SUPPRESS_EN
        check("zero_load_n", load_n, 4'b1111);
        check("zero_busy", busy, 1'b0);
`else
        check("zero_load_n", load_n, 4'b1011);
        check("zero_busy", busy, 1'b1);
`endif
        check("zero_wr", wr_data, 4'h0);
        @(negedge clk);
        check("zero_done_load_n", load_n, 4'b1111);

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
